// File: rtl/block_xfer_seq_pkg.sv
// Shared types and constants for the block transfer sequencer.
// The StWb state only exists when BLOCK_XFER_WB_EN is defined.
package block_xfer_seq_pkg;

    localparam int unsigned WORD_BYTES = 4;

`ifdef BLOCK_XFER_WB_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StWb   = 2'd2,
        StDone = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StDone = 2'd3
    } state_e;
`endif

    // Addressing mode encoded as {pre, up}.
    typedef enum logic [1:0] {
        ModeDa = 2'b00,
        ModeIa = 2'b01,
        ModeDb = 2'b10,
        ModeIb = 2'b11
    } mode_e;

    function automatic logic [4:0] popcount16(logic [15:0] mask);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(mask[i]);
        end
        return cnt;
    endfunction

    function automatic logic [31:0] block_span(logic [4:0] n);
        return 32'(n) * 32'(WORD_BYTES);
    endfunction

    // Lowest address of the block; words are always transferred upward from here.
    function automatic logic [31:0] first_addr(logic [31:0] base, mode_e mode, logic [4:0] n);
        logic [31:0] span;
        logic [31:0] addr;
        span = block_span(n);
        unique case (mode)
            ModeIa:  addr = base;
            ModeIb:  addr = base + 32'(WORD_BYTES);
            ModeDa:  addr = base - span + 32'(WORD_BYTES);
            default: addr = base - span;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/block_xfer_seq_lsb_pick.sv
// Lowest-set-bit selector for the 16-bit register mask (purely combinational).
module lsb_pick (
    input  logic [15:0] mask_i,
    output logic [3:0]  idx_o,
    output logic        none_o
);

    always_comb begin
        idx_o  = 4'd0;
        none_o = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o  = 4'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/block_xfer_seq.sv
// Multi-register load/store sequencer (LDM/STM) with IA/IB/DA/DB addressing.
// Define BLOCK_XFER_WB_EN to enable base register writeback (StWb state).
module block_xfer_seq
    import block_xfer_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reg_list,
    input  logic [3:0]  base_idx,
    input  logic [31:0] base_val,
    input  logic        up,
    input  logic        pre,
    input  logic        wback,
    input  logic [31:0] rf_rdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  rf_idx,
    output logic        rf_latch,
    output logic [31:0] rf_wdata,
    output logic        pc_loaded
);

    state_e      state_q;
    logic [15:0] mask_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  idx_q;

    logic [15:0] pick_mask;
    logic [3:0]  pick_idx;
    logic        pick_none;
    logic        in_xfer;
    logic        ld_word;

`ifdef BLOCK_XFER_WB_EN
    logic [3:0]  base_idx_q;
    logic [31:0] wb_val_q;
    logic        wb_go_q;
`else
    logic unused_wb_inputs;
    assign unused_wb_inputs = ^{wback, base_idx};
`endif

    // In IDLE the picker looks at the incoming list; in XFER at what remains after this word.
    always_comb begin
        pick_mask = mask_q & ~(16'd1 << idx_q);
        if (state_q == StIdle) begin
            pick_mask = reg_list;
        end
    end

    lsb_pick u_lsb_pick (
        .mask_i (pick_mask),
        .idx_o  (pick_idx),
        .none_o (pick_none)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
`ifdef BLOCK_XFER_WB_EN
            base_idx_q <= '0;
            wb_val_q   <= '0;
            wb_go_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mask_q  <= reg_list;
                        we_q    <= ~is_load & ~pick_none;
                        idx_q   <= pick_idx;
                        addr_q  <= pick_none ? '0 :
                                   first_addr(base_val, mode_e'({pre, up}), popcount16(reg_list));
                        state_q <= pick_none ? StDone : StXfer;
`ifdef BLOCK_XFER_WB_EN
                        base_idx_q <= base_idx;
                        wb_val_q   <= up ? base_val + block_span(popcount16(reg_list))
                                         : base_val - block_span(popcount16(reg_list));
                        // A loaded base wins over the writeback value.
                        wb_go_q    <= wback & ~(is_load & reg_list[base_idx]);
`endif
                    end
                end
                StXfer: begin
                    if (mem_ready) begin
                        mask_q <= pick_mask;
                        if (pick_none) begin
                            addr_q <= '0;
                            we_q   <= 1'b0;
`ifdef BLOCK_XFER_WB_EN
                            idx_q   <= wb_go_q ? base_idx_q : 4'd0;
                            state_q <= wb_go_q ? StWb : StDone;
`else
                            idx_q   <= '0;
                            state_q <= StDone;
`endif
                        end else begin
                            addr_q <= addr_q + 32'(WORD_BYTES);
                            idx_q  <= pick_idx;
                        end
                    end
                end
`ifdef BLOCK_XFER_WB_EN
                StWb: begin
                    idx_q   <= '0;
                    state_q <= StDone;
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        in_xfer   = (state_q == StXfer);
        ld_word   = in_xfer & mem_ready & ~we_q;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        mem_req   = in_xfer;
        mem_we    = we_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        rf_idx    = idx_q;
        mem_wdata = (in_xfer & we_q) ? rf_rdata : '0;
        rf_latch  = ld_word;
        rf_wdata  = ld_word ? mem_rdata : '0;
        pc_loaded = ld_word & (idx_q == 4'd15);
`ifdef BLOCK_XFER_WB_EN
        if (state_q == StWb) begin
            rf_latch = 1'b1;
            rf_wdata = wb_val_q;
        end
`endif
    end

endmodule

// File: doc/block_xfer_seq.md
BLOCK_XFER_SEQ -- requirements
Module: block_xfer_seq

Interface
REQ-001 SHALL expose ports as follows (clock and reset first):
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- start  in  1  one-cycle request to begin a block transfer; sampled only in IDLE
- is_load  in  1  1 = LDM (memory to registers), 0 = STM
- reg_list  in  16  register mask; bit i selects Ri
- base_idx  in  4  base register index (Rn)
- base_val  in  32  base register value, sampled with start
- up  in  1  1 = increment addressing, 0 = decrement
- pre  in  1  1 = before-adjust (IB/DB), 0 = after-adjust (IA/DA)
- wback  in  1  base writeback request
- rf_rdata  in  32  register bank read data for rf_idx (store source)
- mem_ready  in  1  memory accepts or returns the current word this cycle
- mem_rdata  in  32  load data, valid when mem_req & mem_ready
- busy  out  1  high from the cycle after start acceptance until DONE inclusive
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store
- mem_addr  out  32  word address (bits 1:0 always 0)
- mem_wdata  out  32  store data
- rf_idx  out  4  register bank index (read index for STM, write index Rd for LDM/writeback)
- rf_latch  out  1  register bank write strobe
- rf_wdata  out  32  register bank write data
- pc_loaded  out  1  one-cycle pulse when R15 is written by an LDM

Function
REQ-002 SHALL implement states IDLE, XFER, WB, DONE.
REQ-003 IDLE: on start=1, SHALL latch all inputs, compute n = popcount(reg_list), and enter XFER (or DONE if n = 0); start outside IDLE SHALL be ignored.
REQ-004 SHALL compute the start address as: IA base; IB base+4; DA base-4n+4; DB base-4n (32-bit, modulo 2^32).
REQ-005 SHALL transfer registers in ascending index order at ascending addresses, +4 per word.
REQ-006 XFER: mem_req SHALL be held high with stable mem_addr/mem_we/rf_idx until mem_ready=1; a word completes only in a cycle with mem_req & mem_ready.
REQ-007 STM: mem_wdata SHALL equal rf_rdata combinationally; rf_latch SHALL stay 0.
REQ-008 LDM: in the completing cycle, rf_latch=1, rf_wdata=mem_rdata, rf_idx = current register; pc_loaded=1 if rf_idx = 15.
REQ-009 After each completed word, SHALL clear that bit from the remaining mask and select the lowest remaining set bit with no idle cycle; after the last word, SHALL go to WB if writeback applies, else DONE.
REQ-010 Writeback applies when wback=1 and NOT (is_load=1 and base_idx is in reg_list); in WB, rf_latch=1, rf_idx=base_idx, rf_wdata = base±4n, for one cycle.
REQ-011 DONE: done=1 for one cycle, then IDLE; mem_req=0 and rf_latch=0 in IDLE, WB (mem_req only) and DONE.
REQ-012 An empty reg_list SHALL perform no memory access and no writeback: start -> DONE -> IDLE.
REQ-013 Latency: n words with mem_ready tied high complete in n cycles of XFER, +1 WB, +1 DONE.

Reset
REQ-014 rst=0 at a clock edge SHALL force IDLE, clear the mask, and drive busy, done, mem_req, mem_we, rf_latch, pc_loaded to 0 and mem_addr, mem_wdata, rf_wdata, rf_idx to 0, including mid-transfer; a reset mid-transfer SHALL abort with no further writes and no done pulse.

Configuration
REQ-015 Macro BLOCK_XFER_WB_EN: when defined, REQ-010 applies; when undefined, the WB state and the writeback adder SHALL be absent, wback SHALL be ignored, and the last word SHALL go directly to DONE.

Structure
REQ-016 A shared package file SHALL hold the state encoding, WORD_BYTES = 4, and the addressing-mode encoding {pre,up}.
REQ-017 The lowest-set-bit selection SHALL be a sub-module lsb_pick (16-bit mask in, 4-bit index plus none flag out, purely combinational).

Verification
REQ-018 STM IA: base 0x8000, list 0x0007, ready high -> stores R0,R1,R2 at 0x8000/0x8004/0x8008 on 3 consecutive cycles; WB writes 0x800C; done is a single pulse.
REQ-019 LDM DB with wback: base_idx 13 = 0x8000, list 0x8010 -> loads R4 @0x7FF8 and R15 @0x7FFC; pc_loaded pulses with R15; R13 is written 0x7FF8.
REQ-020 LDM with base in list: base_idx 2, list 0x0004, wback=1 -> R2 takes the loaded value; no WB cycle.
REQ-021 mem_ready stalls of 0, 2, 3 cycles per word -> mem_addr/rf_idx are stable while stalled; word order is unchanged.
REQ-022 Empty list and start while busy -> no mem_req; done 2 cycles after start; the second start is ignored.
REQ-023 rst=0 during the 2nd word of a 4-word LDM -> next cycle all outputs 0, no further rf_latch, no done pulse.
